// File: rtl/vector_pkg.sv
// Shared definitions for the vector load/store unit: default operand widths,
// the lane-count helper and the store-sequencer state encoding.
package vector_pkg;

  localparam int DEF_VECTOR_WIDTH = 128;
  localparam int DEF_WORD_WIDTH   = 32;

  // Number of memory words that make up one vector operand.
  function automatic int lanes(input int vector_width, input int word_width);
    return vector_width / word_width;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    STORE = 1'b1
  } state_t;

endpackage

// File: rtl/vector_ld_st_unit.sv
// Vector store serializer: latches a vector operand and writes it to the
// 32-bit memory port one lane per cycle, stalling the CPU; scalar stores pass through.
module vector_ld_st_unit
  import vector_pkg::*;
#(
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_wen,
  input  logic                    mem_wen_v,
  input  logic [VECTOR_WIDTH-1:0] input_vector_B,
  input  logic [31:0]             base_addr,
  output logic                    stall_cpu,
  output logic [31:0]             m_address,
  output logic [WORD_WIDTH-1:0]   m_wdata,
  output logic                    m_we
);

  localparam int LANES = lanes(VECTOR_WIDTH, WORD_WIDTH);
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        lane_cnt;
  logic [VECTOR_WIDTH-1:0] vec_q;
  logic [31:0]             base_q;
  logic [WORD_WIDTH-1:0]   lane_word;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (mem_wen_v) state_next = STORE;
      STORE: if (lane_cnt == LAST_LANE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch and lane counter; the vector is captured only on acceptance,
  // so input changes during a burst are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      vec_q    <= '0;
      base_q   <= '0;
    end else if (state == IDLE) begin
      lane_cnt <= '0;
      if (mem_wen_v) begin
        vec_q  <= input_vector_B;
        base_q <= base_addr;
      end
    end else begin
      lane_cnt <= lane_cnt + CNT_W'(1);
    end
  end

  assign lane_word = vec_q[32'(lane_cnt) * WORD_WIDTH +: WORD_WIDTH];

  // Output logic; reset forces the port quiet even while a request is held.
  always_comb begin
    stall_cpu = 1'b0;
    m_we      = 1'b0;
    m_address = base_addr;
    m_wdata   = input_vector_B[WORD_WIDTH-1:0];
    if (rst) begin
      m_address = '0;
      m_wdata   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_wen_v) begin
            stall_cpu = 1'b1;
          end else if (mem_wen) begin
            m_we = 1'b1;
          end
        end
        STORE: begin
          stall_cpu = 1'b1;
          m_we      = 1'b1;
          m_address = base_q + 32'(lane_cnt);
          m_wdata   = lane_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_ld_st_unit.sv
// Self-checking bench for vector_ld_st_unit: directed scenarios then random
// traffic, compared each cycle against a queue-of-pending-writes model.
module tb_vector_ld_st_unit;

  localparam int VW    = 128;
  localparam int WW    = 32;
  localparam int LANES = VW / WW;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_wen;
  logic          mem_wen_v;
  logic [VW-1:0] input_vector_B;
  logic [31:0]   base_addr;
  logic          stall_cpu;
  logic [31:0]   m_address;
  logic [WW-1:0] m_wdata;
  logic          m_we;

  int n_checks = 0;
  int n_errors = 0;
  int exp_writes = 0;
  int seen_writes = 0;
  int stall_run = 0;
  wr_t pend[$];

  vector_ld_st_unit #(.VECTOR_WIDTH(VW), .WORD_WIDTH(WW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_wen        (mem_wen),
    .mem_wen_v      (mem_wen_v),
    .input_vector_B (input_vector_B),
    .base_addr      (base_addr),
    .stall_cpu      (stall_cpu),
    .m_address      (m_address),
    .m_wdata        (m_wdata),
    .m_we           (m_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the
  // model at the rising edge using the same inputs the DUT sampled.
  task automatic step();
    logic        e_stall;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    e_addr = '0;
    e_data = '0;
    if (rst) begin
      e_stall = 1'b0; e_we = 1'b0;
    end else if (pend.size() > 0) begin
      e_stall = 1'b1; e_we = 1'b1;
      e_addr = pend[0].addr; e_data = pend[0].data;
    end else if (mem_wen_v) begin
      e_stall = 1'b1; e_we = 1'b0;
    end else if (mem_wen) begin
      e_stall = 1'b0; e_we = 1'b1;
      e_addr = base_addr; e_data = input_vector_B[31:0];
    end else begin
      e_stall = 1'b0; e_we = 1'b0;
    end
    check("stall_cpu", 32'(stall_cpu), 32'(e_stall));
    check("m_we", 32'(m_we), 32'(e_we));
    if (rst || e_we) begin
      check("m_address", m_address, e_addr);
      check("m_wdata", m_wdata, e_data);
    end
    if (m_we === 1'b1) seen_writes++;
    stall_run = (stall_cpu === 1'b1) ? stall_run + 1 : 0;
    @(posedge clk);
    if (rst) begin
      pend.delete();
    end else if (pend.size() > 0) begin
      void'(pend.pop_front());
      exp_writes++;
    end else if (mem_wen_v) begin
      for (int i = 0; i < LANES; i++) begin
        wr_t w;
        w.addr = base_addr + 32'(i);
        w.data = input_vector_B[i*WW +: WW];
        pend.push_back(w);
      end
    end else if (mem_wen) begin
      exp_writes++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_wen = 1'b0; mem_wen_v = 1'b0;
  endtask

  initial begin
    int max_run;
    rst = 1'b1; mem_wen = 1'b0; mem_wen_v = 1'b1;
    input_vector_B = '1; base_addr = 32'h55;

    // Reset held with a vector request pending: port must stay quiet.
    step(); step();
    rst = 1'b0; idle_inputs();
    step();

    // Directed vector store, then verify the burst's stall length.
    input_vector_B = 128'h12121444511AAAFFFFFFF; base_addr = 32'h100; mem_wen_v = 1'b1;
    step();
    mem_wen_v = 1'b0;
    max_run = 0;
    for (int i = 0; i < LANES + 1; i++) begin
      step();
      if (stall_run > max_run) max_run = stall_run;
    end
    check("burst_stall_len", 32'(max_run), 32'(LANES + 1));
    check("burst_stall_dropped", 32'(stall_cpu), 32'd0);

    // Scalar pass-through.
    input_vector_B = '0; input_vector_B[31:0] = 32'hDEADBEEF; base_addr = 32'h20; mem_wen = 1'b1;
    step();
    idle_inputs();
    step();

    // Both requests together: only the vector burst.
    input_vector_B = {32'h4, 32'h3, 32'h2, 32'h1}; base_addr = 32'h300;
    mem_wen = 1'b1; mem_wen_v = 1'b1;
    step();
    idle_inputs();
    // Inputs changed and a scalar pulse during the burst must be ignored.
    input_vector_B = '1; base_addr = 32'h999; mem_wen = 1'b1;
    step();
    mem_wen = 1'b0;
    for (int i = 0; i < LANES; i++) step();

    // Wrap-around at the top of the address space.
    input_vector_B = {32'hD, 32'hC, 32'hB, 32'hA}; base_addr = 32'hFFFF_FFFE; mem_wen_v = 1'b1;
    step();
    mem_wen_v = 1'b0;
    for (int i = 0; i < LANES + 1; i++) step();

    // Abort a burst with reset after lane 1.
    input_vector_B = {32'h44, 32'h33, 32'h22, 32'h11}; base_addr = 32'h40; mem_wen_v = 1'b1;
    step();
    mem_wen_v = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step();

    // Random traffic, including back-to-back requests and occasional resets.
    for (int n = 0; n < 400; n++) begin
      mem_wen   = ($urandom_range(0, 3) == 0);
      mem_wen_v = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 40) == 0);
      for (int i = 0; i < LANES; i++) input_vector_B[i*WW +: WW] = $urandom;
      base_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      step();
    end
    rst = 1'b0; idle_inputs();
    for (int i = 0; i < LANES + 2; i++) step();

    check("write_count", 32'(seen_writes), 32'(exp_writes));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vector_ld_st_unit.md
Name: vector_ld_st_unit

Overview:
- Vector store serializer between the vector register file and the 32-bit data memory port.
- On a vector store request, it latches the full vector operand (input_vector_B) and a base address.
- It then issues one word write per lane on consecutive cycles and stalls the CPU until all lanes are written.
- Scalar stores (mem_wen) pass straight through in a single cycle with no stall.

Parameters:
- VECTOR_WIDTH, default 128, width of a vector operand in bits. Must be an integer multiple of WORD_WIDTH.
- WORD_WIDTH, default 32, width of one memory word and one lane in bits.
- Derived constant LANES = VECTOR_WIDTH / WORD_WIDTH (4 at defaults).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_wen  input  1  scalar store request.
- mem_wen_v  input  1  vector store request.
- input_vector_B  input  VECTOR_WIDTH  store data; lane i = bits [i*WORD_WIDTH +: WORD_WIDTH].
- base_addr  input  32  word address for the scalar store, or lane-0 address for the vector store.
- stall_cpu  output  1  high while the CPU pipeline must hold.
- m_address  output  32  memory word address.
- m_wdata  output  WORD_WIDTH  memory write data.
- m_we  output  1  memory write strobe, one word per cycle it is high.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE, lane counter 0, latched vector and address cleared.
  - stall_cpu=0, m_we=0, m_address=0, m_wdata=0.
  - Reset mid-burst aborts immediately; no further lane writes are issued.
- FSM states:
  - IDLE: accepts requests.
  - STORE: lane serialization in progress.
- IDLE, mem_wen_v=1 (wins over mem_wen if both are high):
  - stall_cpu=1 combinationally in the same cycle; m_we=0.
  - At the clock edge: latch input_vector_B and base_addr, lane counter := 0, go to STORE.
- IDLE, mem_wen=1 and mem_wen_v=0 (combinational pass-through, no stall):
  - m_we=1, m_address=base_addr, m_wdata=input_vector_B[WORD_WIDTH-1:0].
- IDLE, no request: m_we=0, stall_cpu=0.
  - m_address and m_wdata hold base_addr and lane 0 of the input; don't-care while m_we=0.
- STORE, each cycle with lane counter i:
  - m_we=1, m_address=latched_base+i (32-bit wrap-around at 0xFFFFFFFF→0), m_wdata=latched lane i, stall_cpu=1.
  - Counter increments at the edge.
  - After lane LANES-1, return to IDLE; stall_cpu drops in the following cycle.
- Totals per vector store:
  - stall_cpu high for exactly LANES+1 consecutive cycles (request cycle plus LANES write cycles).
  - Exactly LANES writes, lanes in ascending order.
- mem_wen and mem_wen_v during STORE are ignored; the CPU is stalled and must hold them.
  - A request still held on the first IDLE cycle after a burst is treated as a new request.
- input_vector_B and base_addr changes during STORE have no effect, since the data is latched.
- Addressing is word-granular: consecutive lanes are at consecutive addresses.

Decomposition:
- Shared package vector_pkg holds:
  - VECTOR_WIDTH/WORD_WIDTH defaults and the LANES function.
  - The state typedef enum {IDLE, STORE}.
- Single module; no sub-module is needed. The lane select is an indexed part-select of the latched vector.

Test Plan:
- Reset: assert rst for 2 cycles with mem_wen_v=1 → stall_cpu=0, m_we=0, m_address=0 throughout.
- Vector store: input_vector_B=128'h12121444511AAAFFFFFFF, base_addr=0x100, mem_wen_v pulsed 1 cycle.
  - → stall_cpu high for 5 cycles.
  - → writes (0x100,0xAFFFFFFF), (0x101,0x444511AA), (0x102,0x00012121), (0x103,0x00000000) on 4 consecutive cycles.
- Scalar store: base_addr=0x20, input_vector_B low word 0xDEADBEEF, mem_wen=1 for 1 cycle.
  - → same-cycle m_we=1, m_address=0x20, m_wdata=0xDEADBEEF; stall_cpu stays 0.
- Simultaneous mem_wen=1 and mem_wen_v=1 → vector burst only; no separate scalar write.
- Change input_vector_B and pulse mem_wen during the burst → written data unchanged, no extra writes.
- Wrap and abort:
  - base_addr=0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
  - rst asserted after lane 1 → m_we=0 and stall_cpu=0 from the next cycle.
